// File: rtl/ace_snoop_responder.sv
// ACE snoop responder: takes one AC snoop, looks up the tags, answers on CR, streams the line on CD, then commits the line-state change.
// Min latency AC->CR is 3 cycles; ac_ready is low for the whole transaction, so a new snoop waits until the state update has been accepted.
package ace_snoop_pkg;
  typedef struct packed {
    logic [63:0] addr;
    logic [3:0]  snoop;
    logic [2:0]  prot;
  } ac_chan_t;

  typedef struct packed {
    logic     ac_valid;
    ac_chan_t ac;
    logic     cr_ready;
    logic     cd_ready;
  } snoop_req_t;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
  } cd_chan_t;

  typedef struct packed {
    logic       ac_ready;
    logic       cr_valid;
    logic [4:0] cr_resp;
    logic       cd_valid;
    cd_chan_t   cd;
  } snoop_resp_t;
endpackage

module ace_snoop_responder #(
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned CdBeats   = 4,
  parameter type snoop_req_t  = ace_snoop_pkg::snoop_req_t,
  parameter type snoop_resp_t = ace_snoop_pkg::snoop_resp_t
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  snoop_req_t                 snoop_req_i,
  output snoop_resp_t                snoop_resp_o,
  output logic                       lookup_req_o,
  output logic [AddrWidth-1:0]       lookup_addr_o,
  input  logic                       lookup_gnt_i,
  input  logic                       lookup_valid_i,
  input  logic                       lookup_hit_i,
  input  logic                       lookup_dirty_i,
  input  logic                       lookup_shared_i,
  output logic                       data_req_o,
  output logic [$clog2(CdBeats)-1:0] data_idx_o,
  input  logic                       data_gnt_i,
  input  logic                       data_valid_i,
  input  logic [DataWidth-1:0]       data_i,
  output logic                       upd_valid_o,
  output logic [2:0]                 upd_state_o,
  input  logic                       upd_ready_i,
  output logic                       unsupported_o
);
  localparam int unsigned IdxW = $clog2(CdBeats);
  localparam int unsigned CntW = IdxW + 1;
  localparam int unsigned OffW = $clog2(DataWidth / 8);

  typedef enum logic [2:0] {IDLE, LOOKUP, WAIT_LU, SEND_CR, SEND_CD, UPDATE} state_e;

  state_e                state_q, state_d;
  logic [AddrWidth-1:0]  addr_q;
  logic [3:0]            snoop_q;
  logic [4:0]            cr_q;
  logic                  upd_q;
  logic [2:0]            ust_q;
  logic [CntW-1:0]       req_cnt_q;
  logic                  rd_pend_q;
  logic                  buf_vld_q;
  logic [DataWidth-1:0]  buf_dat_q;
  logic                  buf_last_q;

  logic                  ac_hs, cd_hs, lu_done;
  logic [4:0]            dec_cr;
  logic                  dec_upd, dec_unsup, was_unique;
  logic [2:0]            dec_ust;
  logic                  unused_prot;

  assign unused_prot = ^snoop_req_i.ac.prot;
  assign ac_hs       = (state_q == IDLE) & snoop_req_i.ac_valid;
  assign cd_hs       = buf_vld_q & snoop_req_i.cd_ready;
  assign lu_done     = (state_q == WAIT_LU) & lookup_valid_i;
  assign was_unique  = lookup_hit_i & ~lookup_shared_i;

  // CR bits are {WasUnique, IsShared, PassDirty, Error, DataTransfer}.
  always_comb begin
    dec_cr    = '0;
    dec_upd   = 1'b0;
    dec_ust   = 3'b000;
    dec_unsup = 1'b0;
    case (snoop_q)
      4'b0000:                   dec_cr = {was_unique, 1'b1, 1'b0, 1'b0, 1'b1};
      4'b0001, 4'b0010, 4'b0011: begin
        dec_cr  = {was_unique, 1'b1, lookup_dirty_i, 1'b0, 1'b1};
        dec_upd = 1'b1;
        dec_ust = 3'b101;
      end
      4'b0111: begin
        dec_cr  = {was_unique, 1'b0, lookup_dirty_i, 1'b0, 1'b1};
        dec_upd = 1'b1;
      end
      4'b1001: begin
        dec_cr  = {was_unique, 1'b0, lookup_dirty_i, 1'b0, lookup_dirty_i};
        dec_upd = 1'b1;
      end
      4'b1000: begin
        dec_cr  = {was_unique, 1'b1, lookup_dirty_i, 1'b0, lookup_dirty_i};
        dec_upd = lookup_dirty_i;
        dec_ust = {1'b1, 1'b0, lookup_shared_i};
      end
      4'b1101: begin
        dec_cr  = {was_unique, 4'b0000};
        dec_upd = 1'b1;
      end
      default: dec_unsup = 1'b1;
    endcase
    if (!lookup_hit_i) begin
      dec_cr  = '0;
      dec_upd = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (snoop_req_i.ac_valid) state_d = LOOKUP;
      LOOKUP:  if (lookup_gnt_i) state_d = WAIT_LU;
      WAIT_LU: if (lookup_valid_i) state_d = SEND_CR;
      SEND_CR: if (snoop_req_i.cr_ready) begin
        if (cr_q[0])    state_d = SEND_CD;
        else if (upd_q) state_d = UPDATE;
        else            state_d = IDLE;
      end
      SEND_CD: if (cd_hs && buf_last_q) state_d = upd_q ? UPDATE : IDLE;
      UPDATE:  if (upd_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A new beat is requested only into an empty (or emptying) buffer, one read at a time.
  assign data_req_o = (state_q == SEND_CD) && (req_cnt_q != CntW'(CdBeats)) &&
                      !rd_pend_q && (!buf_vld_q || cd_hs);
  assign data_idx_o = addr_q[OffW +: IdxW] + req_cnt_q[IdxW-1:0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q     <= '0;
      snoop_q    <= '0;
      cr_q       <= '0;
      upd_q      <= 1'b0;
      ust_q      <= 3'b000;
      req_cnt_q  <= '0;
      rd_pend_q  <= 1'b0;
      buf_vld_q  <= 1'b0;
      buf_dat_q  <= '0;
      buf_last_q <= 1'b0;
    end else begin
      if (ac_hs) begin
        addr_q    <= AddrWidth'(snoop_req_i.ac.addr);
        snoop_q   <= snoop_req_i.ac.snoop;
        req_cnt_q <= '0;
      end
      if (lu_done) begin
        cr_q  <= dec_cr;
        upd_q <= dec_upd;
        ust_q <= dec_ust;
      end
      if (data_req_o && data_gnt_i) begin
        rd_pend_q <= 1'b1;
        req_cnt_q <= req_cnt_q + 1'b1;
      end
      if (rd_pend_q && data_valid_i) begin
        rd_pend_q  <= 1'b0;
        buf_vld_q  <= 1'b1;
        buf_dat_q  <= data_i;
        buf_last_q <= (req_cnt_q == CntW'(CdBeats));
      end else if (cd_hs) begin
        buf_vld_q <= 1'b0;
      end
    end
  end

  always_comb begin
    snoop_resp_o          = '0;
    snoop_resp_o.ac_ready = (state_q == IDLE);
    snoop_resp_o.cr_valid = (state_q == SEND_CR);
    snoop_resp_o.cr_resp  = cr_q;
    snoop_resp_o.cd_valid = buf_vld_q;
    snoop_resp_o.cd.data  = buf_dat_q;
    snoop_resp_o.cd.last  = buf_last_q;
  end

  assign lookup_req_o  = (state_q == LOOKUP);
  assign lookup_addr_o = addr_q;
  assign upd_valid_o   = (state_q == UPDATE);
  assign upd_state_o   = ust_q;
  assign unsupported_o = lu_done & dec_unsup;

endmodule

// File: tb/tb_ace_snoop_responder.sv
// Directed bench for ace_snoop_responder: table of snoop vectors with hand-computed CR/CD/update results,
// plus sequences for CD back-pressure and reset in the middle of a line transfer.
module tb_ace_snoop_responder;
  import ace_snoop_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  snoop_req_t  req;
  snoop_resp_t resp;
  logic        lookup_req_o, lookup_gnt_i, lookup_valid_i;
  logic        lookup_hit_i, lookup_dirty_i, lookup_shared_i;
  logic [63:0] lookup_addr_o;
  logic        data_req_o, data_gnt_i, data_valid_i;
  logic [1:0]  data_idx_o;
  logic [63:0] data_i;
  logic        upd_valid_o, upd_ready_i, unsupported_o;
  logic [2:0]  upd_state_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  ace_snoop_responder dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .snoop_req_i(req), .snoop_resp_o(resp),
    .lookup_req_o(lookup_req_o), .lookup_addr_o(lookup_addr_o), .lookup_gnt_i(lookup_gnt_i),
    .lookup_valid_i(lookup_valid_i), .lookup_hit_i(lookup_hit_i),
    .lookup_dirty_i(lookup_dirty_i), .lookup_shared_i(lookup_shared_i),
    .data_req_o(data_req_o), .data_idx_o(data_idx_o), .data_gnt_i(data_gnt_i),
    .data_valid_i(data_valid_i), .data_i(data_i),
    .upd_valid_o(upd_valid_o), .upd_state_o(upd_state_o), .upd_ready_i(upd_ready_i),
    .unsupported_o(unsupported_o)
  );

  typedef struct {
    logic [3:0]  snoop;
    logic [63:0] addr;
    logic        hit, dirty, shared;
    logic [4:0]  cr;
    int          beats;
    int          upd;
    logic [2:0]  ust;
    int          unsup;
    int          stall_beat;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] pat(input int idx, input int vn);
    return 64'hDA7A_0000_0000_0000 | 64'(vn << 8) | 64'(idx);
  endfunction

  task automatic idle_inputs();
    req            = '0;
    lookup_gnt_i   = 1'b0;
    lookup_valid_i = 1'b0;
    lookup_hit_i   = 1'b0;
    lookup_dirty_i = 1'b0;
    lookup_shared_i = 1'b0;
    data_gnt_i     = 1'b0;
    data_valid_i   = 1'b0;
    data_i         = '0;
    upd_ready_i    = 1'b0;
  endtask

  // Plays CCU, tag array and data array for one snoop; returns early once abort_beats CD beats are accepted.
  task automatic run_vec(input vec_t v, input int vn, input int abort_beats);
    int beats = 0, reqs = 0, upds = 0, unsups = 0, stall_cnt = 0, cr_lat = -1, dv_idx = 0;
    logic lu_pend = 1'b0, dv_pend = 1'b0, cr_done = 1'b0, done = 1'b0;
    logic [2:0] ust = 3'b000;
    logic [63:0] held = '0;
    int s = int'(v.addr[4:3]);
    string t = $sformatf("v%0d", vn);
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk_i);
      req.ac_valid    = (c == 0);
      req.ac.addr     = v.addr;
      req.ac.snoop    = v.snoop;
      req.ac.prot     = 3'b010;
      lookup_valid_i  = lu_pend;
      lookup_hit_i    = v.hit;
      lookup_dirty_i  = v.dirty;
      lookup_shared_i = v.shared;
      lu_pend         = 1'b0;
      data_valid_i    = dv_pend;
      data_i          = pat(dv_idx, vn);
      dv_pend         = 1'b0;
      req.cd_ready    = !(beats == v.stall_beat && stall_cnt < 5);
      req.cr_ready    = 1'b1;
      upd_ready_i     = 1'b1;
      #1;
      if (c == 0) begin
        chk({t, "_ac_ready_idle"}, resp.ac_ready, 1);
      end else if (resp.ac_ready) begin
        done = 1'b1;
      end else begin
        if (unsupported_o) unsups++;
        lookup_gnt_i = lookup_req_o;
        if (lookup_req_o) begin
          lu_pend = 1'b1;
          chk({t, "_lookup_addr"}, lookup_addr_o, v.addr);
        end
        if (resp.cr_valid && !cr_done) begin
          cr_lat  = c;
          cr_done = 1'b1;
          chk({t, "_cr_resp"}, resp.cr_resp, v.cr);
        end
        if (resp.cd_valid) begin
          chk({t, "_cd_after_cr"}, cr_done, 1);
          if (req.cd_ready) begin
            chk($sformatf("%s_cd_data%0d", t, beats), resp.cd.data, pat((s + beats) % 4, vn));
            chk($sformatf("%s_cd_last%0d", t, beats), resp.cd.last, beats == 3);
            beats++;
          end else begin
            if (stall_cnt == 0) held = resp.cd.data;
            else chk({t, "_cd_hold"}, resp.cd.data, held);
            chk({t, "_no_req_in_stall"}, data_req_o, 0);
            stall_cnt++;
          end
        end
        data_gnt_i = data_req_o;
        if (data_req_o) begin
          chk($sformatf("%s_idx%0d", t, reqs), data_idx_o, (s + reqs) % 4);
          dv_pend = 1'b1;
          dv_idx  = int'(data_idx_o);
          reqs++;
        end
        if (upd_valid_o) begin
          upds++;
          ust = upd_state_o;
          chk({t, "_upd_after_cd"}, beats, v.beats);
        end
        if (abort_beats >= 0 && beats == abort_beats) return;
      end
    end
    req            = '0;
    lookup_gnt_i   = 1'b0;
    data_gnt_i     = 1'b0;
    lookup_valid_i = 1'b0;
    data_valid_i   = 1'b0;
    chk({t, "_done_in_budget"}, done, 1);
    chk({t, "_cr_latency"}, cr_lat, 3);
    chk({t, "_cd_beats"}, beats, v.beats);
    chk({t, "_upd_count"}, upds, v.upd);
    if (v.upd != 0) chk({t, "_upd_state"}, ust, v.ust);
    chk({t, "_unsup_count"}, unsups, v.unsup);
    if (v.stall_beat >= 0) chk({t, "_stall_cycles"}, stall_cnt, 5);
  endtask

  vec_t vecs[13];
  vec_t vr;

  initial begin
    //         snoop    addr      hit   dirty shared cr        beats upd ust     unsup stall
    vecs[0]  = '{4'b1001, 64'h1010, 1'b1, 1'b1, 1'b0, 5'b10101, 4, 1, 3'b000, 0, -1};
    vecs[1]  = '{4'b0001, 64'h0040, 1'b1, 1'b0, 1'b1, 5'b01001, 4, 1, 3'b101, 0, -1};
    vecs[2]  = '{4'b1101, 64'h2000, 1'b1, 1'b1, 1'b1, 5'b00000, 0, 1, 3'b000, 0, -1};
    vecs[3]  = '{4'b1101, 64'h2008, 1'b1, 1'b1, 1'b0, 5'b10000, 0, 1, 3'b000, 0, -1};
    vecs[4]  = '{4'b0111, 64'h3000, 1'b0, 1'b1, 1'b0, 5'b00000, 0, 0, 3'b000, 0, -1};
    vecs[5]  = '{4'b1110, 64'h3010, 1'b1, 1'b1, 1'b0, 5'b00000, 0, 0, 3'b000, 1, -1};
    vecs[6]  = '{4'b1110, 64'h3018, 1'b0, 1'b0, 1'b0, 5'b00000, 0, 0, 3'b000, 1, -1};
    vecs[7]  = '{4'b0000, 64'h0018, 1'b1, 1'b1, 1'b0, 5'b11001, 4, 0, 3'b000, 0, -1};
    vecs[8]  = '{4'b1000, 64'h4000, 1'b1, 1'b1, 1'b1, 5'b01101, 4, 1, 3'b101, 0, -1};
    vecs[9]  = '{4'b1000, 64'h4008, 1'b1, 1'b0, 1'b0, 5'b11000, 0, 0, 3'b000, 0, -1};
    vecs[10] = '{4'b0011, 64'h1008, 1'b1, 1'b1, 1'b0, 5'b11101, 4, 1, 3'b101, 0, 1};
    vecs[11] = '{4'b1001, 64'h5000, 1'b1, 1'b0, 1'b0, 5'b10000, 0, 1, 3'b000, 0, -1};
    vecs[12] = '{4'b0010, 64'h5010, 1'b0, 1'b0, 1'b0, 5'b00000, 0, 0, 3'b000, 0, -1};

    idle_inputs();
    rst_ni = 1'b0;
    #1;
    chk("rst_ac_ready", resp.ac_ready, 1);
    chk("rst_cr_valid", resp.cr_valid, 0);
    chk("rst_cd_valid", resp.cd_valid, 0);
    chk("rst_lookup_req", lookup_req_o, 0);
    chk("rst_data_req", data_req_o, 0);
    chk("rst_upd_valid", upd_valid_o, 0);
    chk("rst_unsupported", unsupported_o, 0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;

    for (int i = 0; i < 13; i++) run_vec(vecs[i], i, -1);

    // Reset while the line is streaming: outputs drop at once and no update follows.
    vr = vecs[0];
    run_vec(vr, 20, 2);
    idle_inputs();
    rst_ni = 1'b0;
    #1;
    chk("midrst_cd_valid", resp.cd_valid, 0);
    chk("midrst_data_req", data_req_o, 0);
    chk("midrst_upd_valid", upd_valid_o, 0);
    chk("midrst_cr_valid", resp.cr_valid, 0);
    chk("midrst_ac_ready", resp.ac_ready, 1);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      #1;
      chk($sformatf("postrst_upd_valid%0d", i), upd_valid_o, 0);
      chk($sformatf("postrst_ac_ready%0d", i), resp.ac_ready, 1);
    end
    run_vec(vecs[1], 21, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
